// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef logic port_id_t;
  localparam int NPORTS = 2;
  localparam int DEPTH_DEFAULT = 256;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select; DMEM_ARB_RR_EN selects round-robin, else port 0 priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  port_id_t          last,
  output port_id_t          win
);
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  always_comb win = (&req && RR) ? ~last : ~req[0];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two masters onto a single-port data memory via IDLE/ACCESS/RESP.
// DMEM_ARB_RR_EN enables round-robin arbitration with a last-winner register.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ack,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [AW-1:0] LIMIT = AW'(4 * DEPTH);
  state_t state, state_n;
  port_id_t id, win, last;
  logic cmd_we, bad, err_q, grant;
  logic [AW-1:0] cmd_addr, win_addr;
  logic [DW-1:0] cmd_wdata, rdata_q;
  assign grant = state == IDLE && |req;
  assign win_addr = win ? addr1 : addr0;
  dmem_arb_pick u_pick (.req, .last, .win);
`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 1'b1;
    else if (grant) last <= win;
`else
  assign last = 1'b1;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (|req ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id        <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      bad       <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (grant) begin
        id        <= win;
        cmd_we    <= we[win];
        cmd_addr  <= win_addr;
        cmd_wdata <= win ? wdata1 : wdata0;
        bad       <= win_addr[1:0] != 2'b00 || win_addr >= LIMIT;
      end
      if (state == ACCESS) begin
        err_q   <= bad;
        rdata_q <= (bad || cmd_we) ? '0 : mem_rdata;
      end
    end
  end
  // memory strobes derive from state so an async reset kills them immediately
  always_comb begin
    mem_read  = state == ACCESS && !bad && !cmd_we;
    mem_write = state == ACCESS && !bad && cmd_we;
    mem_addr  = cmd_addr;
    mem_wdata = cmd_wdata;
    ack       = state == RESP ? 2'b01 << id : 2'b00;
    err       = state == RESP && err_q;
    rdata     = state == RESP ? rdata_q : '0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized checks against a shadow-memory reference model.
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = '0, we = '0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0] ack;
  logic err, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] model [256];
  int n_chk = 0, n_fail = 0;
  bit model_last = 1'b1;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  dmem_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .err(err), .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_port(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
    req[p] = 1'b1;
    we[p] = w;
    if (p == 1) begin addr1 = a; wdata1 = d; end
    else begin addr0 = a; wdata0 = d; end
  endtask
  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    if (k == 0) return 32'h400 + 4 * $urandom_range(0, 255);
    if (k == 1) return 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
    return 4 * $urandom_range(0, 15);
  endfunction
  // one full transaction: predicts the winner, then checks ACCESS, RESP and the following IDLE
  task automatic step(input bit hold);
    int w;
    logic [31:0] a, d, exp_rd;
    bit wr, bad;
    w = (req == 2'b11) ? (RR ? int'(!model_last) : 0) : (req[1] ? 1 : 0);
    if (RR) model_last = w[0];
    a = (w == 1) ? addr1 : addr0;
    d = (w == 1) ? wdata1 : wdata0;
    wr = we[w];
    bad = a[1:0] != 2'b00 || a >= 32'd1024;
    exp_rd = (bad || wr) ? 32'h0 : model[a[9:2]];
    @(posedge clk); #1;
    chk("access_ack", ack, 0);
    chk("mem_read", mem_read, !bad && !wr);
    chk("mem_write", mem_write, !bad && wr);
    if (!bad) chk("mem_addr", mem_addr, a);
    if (!bad && wr) chk("mem_wdata", mem_wdata, d);
    if (!bad && wr) model[a[9:2]] = d;
    @(posedge clk); #1;
    chk("ack", ack, 2'b01 << w);
    chk("err", err, bad);
    chk("rdata", rdata, exp_rd);
    chk("resp_mem_read", mem_read, 0);
    @(posedge clk); #1;
    chk("idle_ack", ack, 0);
    if (!hold) req[w] = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_port(i % 2, 1'b1, 4 * i, $urandom);
      step(1'b0);
    end
    set_port(0, 1'b1, 32'h10, 32'hDEADBEEF); step(1'b0);
    set_port(0, 1'b0, 32'h10, 32'h0); step(1'b0);
    chk("deadbeef_mem", mem[4], 32'hDEADBEEF);
    set_port(0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 32'h4, 32'h0);
    repeat (4) step(1'b1);
    step(1'b0);
    step(1'b0);
    set_port(0, 1'b0, 32'h400, 32'h0); step(1'b0);
    set_port(1, 1'b0, 32'h13, 32'h0); step(1'b0);
    set_port(0, 1'b1, 32'h11, 32'h12345678); step(1'b0);
    set_port(1, 1'b1, 32'h20, 32'h55); step(1'b0);
    set_port(1, 1'b0, 32'h20, 32'h0); step(1'b0);
    set_port(0, 1'b1, 32'h8, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("pre_rst_mem_write", mem_write, 1);
    rst = 1'b1;
    req = '0;
    #1;
    chk("rst_mid_mem_write", mem_write, 0);
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    @(negedge clk); rst = 1'b0;
    model_last = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack", ack, 0);
    chk("post_rst_mem_read", mem_read, 0);
    set_port(0, 1'b0, 32'h8, 32'h0); step(1'b0);
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_ack", ack, 0);
      chk("idle_mem_read", mem_read, 0);
      chk("idle_mem_write", mem_write, 0);
    end
    repeat (60) begin
      int r = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++)
        if (r[p]) set_port(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      step(1'b0);
      if (r == 3) step(1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer sitting in front of the single-port data memory (256 x 32-bit, word-addressed by addr[9:2], combinational read, write on clock edge). It lets the CPU load/store unit (port 0) and a secondary master such as a DMA or debug loader (port 1) share the memory. It serialises their requests through a three-state FSM, range- and alignment-checks each address, and returns registered read data with a one-cycle acknowledge pulse.

## Interface
- DEPTH, 256: memory depth in words; legal byte addresses are 0 .. 4*DEPTH-1.
- AW, 32: address width.
- DW, 32: data width.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  per-port request; bit i belongs to port i.
- we  in  2  per-port write enable; 1 = write, 0 = read. Sampled with req.
- addr0, addr1  in  AW  per-port byte address.
- wdata0, wdata1  in  DW  per-port write data.
- ack  out  2  one-cycle completion pulse per port.
- err  out  1  valid with ack; 1 = request rejected (out of range or misaligned).
- rdata  out  DW  read data; valid with ack for reads, 0 otherwise.
- mem_read, mem_write  out  1  memory controls (MemRead/MemWrite).
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data (combinational).

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If any req bit is high, select a winner.
  - Latch the winner's id, we, addr and wdata into command registers.
  - Compute bad = (addr[1:0] != 0) or (addr >= 4*DEPTH), then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - If !bad: drive mem_addr = latched addr, mem_write = latched we, mem_read = !we, mem_wdata = latched wdata.
  - For a read, capture mem_rdata into the rdata register.
  - If bad: mem_read = mem_write = 0, rdata register cleared, err register set.
  - Go to RESP.
- RESP: ack[id] = 1 for exactly this cycle; err and rdata are valid. Go to IDLE.
- Memory outputs are decoded from state plus command registers. Outside ACCESS, mem_read = mem_write = 0, and mem_addr/mem_wdata hold the latched values.
- Requester rule:
  - Hold req, we, addr and wdata stable until ack.
  - Drop req on the edge that ends the ack cycle.
  - A req still high in the next IDLE cycle is a new request.
  - The arbiter never cancels a request once it is latched.
- A write is committed at the rising edge that ends ACCESS; data is readable from the next request onward.

## Timing
- Request sampled in IDLE at cycle N: memory access in N+1, ack in N+2. Next IDLE is N+3.
- Peak throughput is one access per 3 cycles.
- Reset values: ack = 0, err = 0, rdata = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, last-winner = 1, state IDLE.
- Reset asserted mid-ACCESS forces mem_write low immediately (asynchronous, via state). The pending request is dropped with no ack, and the requester must re-issue it.
- Both requests arriving in the same IDLE cycle: the winner is resolved per Configuration; the loser stays pending and is served after the winner's RESP.
- A req that rises during ACCESS or RESP is first seen in the next IDLE.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin.
  - A last-winner register updates in IDLE when a grant is made.
  - On conflict, the port opposite last-winner wins; port 0 wins the first conflict after reset.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins. No last-winner register is built.

## Structure
- Package dmem_arb_pkg holds:
  - state enum (IDLE, ACCESS, RESP);
  - port-id typedef (1 bit);
  - constants NPORTS = 2 and DEPTH_DEFAULT = 256.
- Optional sub-module dmem_arb_pick: combinational winner select from req and last-winner, with the macro handled inside it. Everything else lives in dmem_arbiter.

## Test plan
- Port 0 write 0xDEADBEEF to 0x10, then read 0x10 -> ack[0] at N+2 each time; read returns rdata = 0xDEADBEEF, err = 0.
- Both ports read in the same cycle, repeated 4 times with req held -> RR: grants 0,1,0,1 (one per 3 cycles); without macro: port 0 serviced every time, port 1 starved while port 0 is held.
- Read address 0x400 (DEPTH = 256) and 0x13 -> mem_read and mem_write stay 0, ack with err = 1 and rdata = 0.
- Write 0x55 to 0x20, then read 0x20 in the very next IDLE -> returns 0x55.
- Assert rst during the ACCESS cycle of a write to 0x8 -> mem_write drops the same cycle, no ack, state IDLE; a following read of 0x8 returns the prior contents.
- Idle 10 cycles with req = 0 -> ack, mem_read and mem_write remain 0.
